kamacore_mem_arbiter: RTL and testbench

- Sits between the core-side requesters and the dual-port memory macro.
- Port A (read/write): round-robin shared between requester 0 (LSU) and requester 1 (debug/program loader).
- Port B (read-only): instruction fetch, passed straight through.
- Sub-word stores are built as read-modify-write sequences, because the memory has no byte enables.

---
 rtl/kamacore_mem_arbiter_if.sv | 33 +++
 rtl/kamacore_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_kamacore_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamacore_mem_arbiter_if.sv
// Shared constants and the requester-side handshake bundle for kamacore_mem_arbiter.
// One interface instance per requester: request fields in, ready and response back.
package kamacore_pkg;
  parameter int CPU_WIDTH  = 32;
  parameter int BE_W       = CPU_WIDTH / 8;
  parameter int ADDR_WIDTH = 12;
endpackage

interface kamacore_mem_arbiter_if
  import kamacore_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH
);
  logic                      valid;
  logic                      ready;
  logic                      we;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [CPU_WIDTH-1:0]      wdata;
  logic [BE_W-1:0]           be;
  logic                      rsp_valid;
  logic [CPU_WIDTH-1:0]      rsp_rdata;
  logic                      rsp_err;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/kamacore_mem_arbiter.sv
// Port-A round-robin arbiter (LSU / debug loader) with read-modify-write for sub-word stores;
// port B is a combinational fetch pass-through. Optional: KAMACORE_MEM_BOUNDS_CHECK_EN.
module kamacore_mem_arbiter
  import kamacore_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int RAM_SIZE       = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  kamacore_mem_arbiter_if.slave     req0,
  kamacore_mem_arbiter_if.slave     req1,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
  output logic [CPU_WIDTH-1:0]      if_data,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic [CPU_WIDTH-1:0]      mem_di,
  input  logic [CPU_WIDTH-1:0]      mem_spo,
  output logic [MEM_ADDR_WIDTH-1:0] mem_dpra,
  input  logic [CPU_WIDTH-1:0]      mem_dpo
);

`ifdef KAMACORE_MEM_BOUNDS_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif
  localparam logic [MEM_ADDR_WIDTH:0] RAM_LIMIT = (MEM_ADDR_WIDTH+1)'(RAM_SIZE);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t                         state_reg;
  logic                           last_grant_reg;
  logic [MEM_ADDR_WIDTH-1:0]      mem_a_reg;
  logic [MEM_ADDR_WIDTH-1:0]      lat_addr_reg;
  logic [CPU_WIDTH-1:0]           lat_wdata_reg;
  logic [BE_W-1:0]                lat_be_reg;
  logic                           lat_req_reg;
  logic [1:0]                     rsp_valid_reg;
  logic [1:0]                     rsp_err_reg;
  logic [1:0][CPU_WIDTH-1:0]      rsp_rdata_reg;

  logic                           any_valid;
  logic                           grant;
  logic                           accept;
  logic                           sel_we;
  logic [MEM_ADDR_WIDTH-1:0]      sel_addr;
  logic [CPU_WIDTH-1:0]           sel_wdata;
  logic [BE_W-1:0]                sel_be;
  logic                           sel_oob;
  logic                           sel_full;
  logic                           sel_partial;
  logic [CPU_WIDTH-1:0]           merge_data;

  // Fetch port never interacts with arbitration.
  assign mem_dpra = if_addr;
  assign if_data  = mem_dpo;

  assign any_valid = req0.valid | req1.valid;

  always_comb begin
    grant = 1'b0;
    if (req0.valid && req1.valid) grant = ~last_grant_reg;
    else if (req1.valid)          grant = 1'b1;
  end

  // Reset gates acceptance so nothing is granted that the reset would then drop.
  assign accept     = rst_n && (state_reg == IDLE) && any_valid;
  assign req0.ready = accept && !grant;
  assign req1.ready = accept && grant;

  assign sel_we    = grant ? req1.we    : req0.we;
  assign sel_addr  = grant ? req1.addr  : req0.addr;
  assign sel_wdata = grant ? req1.wdata : req0.wdata;
  assign sel_be    = grant ? req1.be    : req0.be;

  assign sel_oob     = RANGE_CHECK && ({1'b0, sel_addr} >= RAM_LIMIT);
  assign sel_full    = &sel_be;
  assign sel_partial = sel_we && !sel_oob && !sel_full && (|sel_be);

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
      assign merge_data[8*gi +: 8] = lat_be_reg[gi] ? lat_wdata_reg[8*gi +: 8]
                                                    : mem_spo[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    mem_we = 1'b0;
    if (rst_n) begin
      if (state_reg == MERGE)                                mem_we = 1'b1;
      else if (accept && sel_we && sel_full && !sel_oob)     mem_we = 1'b1;
    end
  end

  assign mem_a  = (state_reg == MERGE) ? lat_addr_reg :
                  accept               ? sel_addr     : mem_a_reg;
  assign mem_di = (state_reg == MERGE) ? merge_data : sel_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      mem_a_reg      <= '0;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
      lat_be_reg     <= '0;
      lat_req_reg    <= 1'b0;
      rsp_valid_reg  <= '0;
      rsp_err_reg    <= '0;
      rsp_rdata_reg  <= '0;
    end else begin
      rsp_valid_reg <= '0;
      rsp_err_reg   <= '0;
      mem_a_reg     <= mem_a;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            last_grant_reg <= grant;
            if (sel_partial) begin
              state_reg     <= MERGE;
              lat_addr_reg  <= sel_addr;
              lat_wdata_reg <= sel_wdata;
              lat_be_reg    <= sel_be;
              lat_req_reg   <= grant;
            end else begin
              rsp_valid_reg[grant] <= 1'b1;
              rsp_err_reg[grant]   <= sel_oob;
              rsp_rdata_reg[grant] <= (!sel_we && !sel_oob) ? mem_spo : '0;
            end
          end
        end
        MERGE: begin
          state_reg                  <= IDLE;
          rsp_valid_reg[lat_req_reg] <= 1'b1;
          rsp_rdata_reg[lat_req_reg] <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req0.rsp_valid = rsp_valid_reg[0];
  assign req1.rsp_valid = rsp_valid_reg[1];
  assign req0.rsp_err   = rsp_err_reg[0];
  assign req1.rsp_err   = rsp_err_reg[1];
  assign req0.rsp_rdata = rsp_rdata_reg[0];
  assign req1.rsp_rdata = rsp_rdata_reg[1];

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Directed plus randomized bench for kamacore_mem_arbiter against a word-array reference model.
module tb_kamacore_mem_arbiter;
  import kamacore_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int RS = 1024;
`ifdef KAMACORE_MEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_data;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_di;
  logic [31:0]   mem_spo;
  logic [AW-1:0] mem_dpra;
  logic [31:0]   mem_dpo;

  always #5 clk = ~clk;

  kamacore_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW)) r0 ();
  kamacore_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW)) r1 ();

  kamacore_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .RAM_SIZE(RS)) dut (
    .clk(clk), .rst_n(rst_n), .req0(r0), .req1(r1),
    .if_addr(if_addr), .if_data(if_data),
    .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_spo(mem_spo),
    .mem_dpra(mem_dpra), .mem_dpo(mem_dpo)
  );

  // Dual-port memory macro: async reads, synchronous write on port A.
  logic [31:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_a] <= mem_di;
    end
  end
  assign mem_spo = ram[mem_a];
  assign mem_dpo = ram[mem_dpra];

  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          model_last;
  int          n_checks = 0;
  int          n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8*b));
    return (old & ~mask) | (wd & mask);
  endfunction

  task automatic set_req(input int n, input logic v, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    if (n == 0) begin
      r0.valid = v; r0.we = we; r0.addr = addr; r0.wdata = wdata; r0.be = be;
    end else begin
      r1.valid = v; r1.we = we; r1.addr = addr; r1.wdata = wdata; r1.be = be;
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? r0.ready : r1.ready;
  endfunction
  function automatic logic rspv(input int n);
    return (n == 0) ? r0.rsp_valid : r1.rsp_valid;
  endfunction
  function automatic logic [31:0] rspd(input int n);
    return (n == 0) ? r0.rsp_rdata : r1.rsp_rdata;
  endfunction
  function automatic logic rspe(input int n);
    return (n == 0) ? r0.rsp_err : r1.rsp_err;
  endfunction

  // Single transaction from one requester; expectations come from the reference array.
  task automatic do_req(input int n, input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int          waitc;
    logic        oob, wr, partial;
    logic [31:0] exp_rd, exp_di;
    set_req(n, 1'b1, we, addr, wdata, be);
    settle();
    waitc = 0;
    while (!rdy(n) && waitc < 20) begin
      tick();
      waitc++;
    end
    if (!rdy(n)) begin
      chk("ready_timeout", rdy(n), 1'b1);
      set_req(n, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    oob     = BCHK && (addr >= RS);
    wr      = we && !oob && (be != 4'h0);
    partial = wr && (be != 4'hF);
    chk("ready_other", rdy(1-n), 1'b0);
    chk("mem_we_accept", mem_we, wr && !partial);
    if (wr && !partial) chk("mem_di_full", mem_di, wdata);
    exp_rd = (!we && !oob) ? ref_mem[addr] : 32'h0;
    exp_di = merge(ref_mem[addr], wdata, be);
    if (wr) ref_mem[addr] = exp_di;
    model_last = n;
    $display("txn req%0d we=%0b addr=%0d wdata=%h be=%b exp_rdata=%h oob=%0b",
             n, we, addr, wdata, be, exp_rd, oob);
    tick();
    if (partial) begin
      chk("merge_ready", rdy(n), 1'b0);
      chk("merge_we", mem_we, 1'b1);
      chk("merge_di", mem_di, exp_di);
      chk("merge_addr", 32'(mem_a), 32'(addr));
      chk("merge_no_rsp", rspv(n), 1'b0);
      tick();
    end
    set_req(n, 1'b0, 1'b0, '0, '0, '0);
    chk("rsp_valid", rspv(n), 1'b1);
    chk("rsp_rdata", rspd(n), exp_rd);
    chk("rsp_err", rspe(n), oob);
    chk("rsp_other", rspv(1-n), 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    int            g;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    if_addr = '0;
    rst_n   = 1'b0;
    tick();
    tick();
    chk("rst_rsp0_valid", r0.rsp_valid, 1'b0);
    chk("rst_rsp1_valid", r1.rsp_valid, 1'b0);
    chk("rst_rsp0_rdata", r0.rsp_rdata, 32'h0);
    chk("rst_rsp1_rdata", r1.rsp_rdata, 32'h0);
    chk("rst_rsp0_err", r0.rsp_err, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    rst_n = 1'b1;
    model_last = 1;
    tick();
    chk("idle_mem_we", mem_we, 1'b0);

    // Full write then read back
    do_req(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
    do_req(0, 1'b0, 5, 32'h0, 4'h0);
    chk("plan_read5", r0.rsp_rdata, 32'hDEADBEEF);

    // Sub-word store through read-modify-write
    do_req(1, 1'b1, 5, 32'h00001234, 4'b0011);
    do_req(0, 1'b0, 5, 32'h0, 4'h0);
    chk("plan_partial5", r0.rsp_rdata, 32'hDEAD1234);

    // Round-robin with both requesters holding reads
    do_req(0, 1'b1, 7, 32'hA5A5A5A5, 4'hF);
    do_req(1, 1'b1, 8, 32'h5A5A5A5A, 4'hF);
    set_req(0, 1'b1, 1'b0, 7, '0, '0);
    set_req(1, 1'b1, 1'b0, 8, '0, '0);
    settle();
    for (int k = 0; k < 4; k++) begin
      g = 1 - model_last;
      chk("rr_ready0", r0.ready, g == 0);
      chk("rr_ready1", r1.ready, g == 1);
      chk("rr_not_both", r0.ready & r1.ready, 1'b0);
      $display("txn arbitration cycle %0d expected grant req%0d", k, g);
      model_last = g;
      tick();
      chk("rr_rsp_valid", rspv(g), 1'b1);
      chk("rr_rsp_rdata", rspd(g), ref_mem[(g == 0) ? 7 : 8]);
      chk("rr_rsp_other", rspv(1-g), 1'b0);
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Fetch sees old word in the write cycle, new word afterwards
    if_addr = 5;
    set_req(0, 1'b1, 1'b1, 5, 32'h11111111, 4'hF);
    settle();
    chk("fetch_ready", r0.ready, 1'b1);
    chk("fetch_old", if_data, ref_mem[5]);
    chk("fetch_we", mem_we, 1'b1);
    $display("txn req0 we=1 addr=5 wdata=11111111 be=1111 with fetch on addr 5");
    ref_mem[5] = 32'h11111111;
    model_last = 0;
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    chk("fetch_new", if_data, 32'h11111111);
    chk("fetch_rsp", r0.rsp_valid, 1'b1);

    // Reset during the merge cycle drops the store
    set_req(1, 1'b1, 1'b1, 5, 32'hFFFF0000, 4'b1100);
    settle();
    chk("rstm_ready", r1.ready, 1'b1);
    $display("txn req1 we=1 addr=5 wdata=ffff0000 be=1100 interrupted by reset");
    tick();
    rst_n = 1'b0;
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("rstm_no_we", mem_we, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("rstm_rsp0", r0.rsp_valid, 1'b0);
    chk("rstm_rsp1", r1.rsp_valid, 1'b0);
    set_req(0, 1'b1, 1'b0, 5, '0, '0);
    set_req(1, 1'b1, 1'b0, 7, '0, '0);
    settle();
    chk("rstm_grant0", r0.ready, 1'b1);
    chk("rstm_grant1", r1.ready, 1'b0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    chk("rstm_word", r0.rsp_rdata, 32'h11111111);
    chk("rstm_rsp_valid", r0.rsp_valid, 1'b1);
    model_last = 0;
    tick();

    // Range boundary, out-of-range partial, zero byte-enable write
    do_req(0, 1'b1, 1024, 32'hCAFEF00D, 4'hF);
    chk("bounds_err", r0.rsp_err, BCHK);
    do_req(1, 1'b1, 1025, 32'h01020304, 4'b0101);
    do_req(0, 1'b0, 1024, 32'h0, 4'h0);
    do_req(0, 1'b1, 1023, 32'h76543210, 4'hF);
    do_req(1, 1'b0, 1023, 32'h0, 4'h0);
    do_req(0, 1'b1, 9, 32'h99999999, 4'h0);
    do_req(1, 1'b0, 9, 32'h0, 4'h0);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      ra = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1020, 1030))
                                       : AW'($urandom_range(0, 15));
      do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), ra, $urandom,
             4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
